// File: rtl/button_debounce_multi_if.sv
// Button bank bus: raw button pins in, debounced level and event pulses out.
interface button_debounce_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] button;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] btn_press;
  logic [CHANNELS-1:0] btn_release;
  logic [CHANNELS-1:0] btn_long;

  modport master (output button, input btn_level, btn_press, btn_release, btn_long);
  modport slave  (input button, output btn_level, btn_press, btn_release, btn_long);
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel button debouncer: per-channel sync, restartable stability check, press/release pulses.
// Define BTN_LONG_PRESS_EN to enable the one-shot long-press pulse on btn_long.
module btn_debounce_lane #(
  parameter int DELAY = 1500000
`ifdef BTN_LONG_PRESS_EN
  , parameter int HOLD_CYC = 98500000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

`ifdef BTN_LONG_PRESS_EN
  localparam int CW = $clog2(DELAY + HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
`else
  localparam int CW = $clog2(DELAY + 1);
`endif
  localparam int RW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(DELAY - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(DELAY - 1);

  logic [1:0]    sync;
  logic          s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] cnt_rel, cnt_rel_n;
  logic          press_n, rel_n, long_n;
  logic          lvl_q;
  logic [2:0]    evt_q;

  assign s = sync[1];

  // Decisions are registered into lvl_q/evt_q and retimed once more onto the
  // outputs, giving a k+2+DELAY edge latency from the first sampled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      state   <= IDLE;
      cnt     <= '0;
      cnt_rel <= '0;
      lvl_q   <= 1'b0;
      evt_q   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      long_p  <= 1'b0;
    end else begin
      sync    <= {sync[0], button};
      state   <= state_n;
      cnt     <= cnt_n;
      cnt_rel <= cnt_rel_n;
      lvl_q   <= (state_n == HELD) || (state_n == REL_CHK);
      evt_q   <= {long_n, rel_n, press_n};
      level   <= lvl_q;
      press   <= evt_q[0];
      rel     <= evt_q[1];
      long_p  <= evt_q[2];
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cnt_rel_n = cnt_rel;
    press_n   = 1'b0;
    rel_n     = 1'b0;
    long_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        cnt_rel_n = '0;
        if (s) begin
          state_n = PRESS_CHK;
          cnt_n   = CW'(1);
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == ACC_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_n   = REL_CHK;
          cnt_rel_n = RW'(1);
        end
`ifdef BTN_LONG_PRESS_EN
        // Hold count stops at HOLD_MAX so the long pulse fires once per press.
        else if (cnt < HOLD_MAX) begin
          cnt_n  = cnt + 1'b1;
          long_n = (cnt == HOLD_LAST);
        end
`endif
      end
      REL_CHK: begin
        if (s) begin
          state_n = HELD;
        end else if (cnt_rel == REL_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else begin
          cnt_rel_n = cnt_rel + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

module button_debounce_multi #(
  parameter int CHANNELS   = 4,
  parameter int DELAY      = 1500000,
  parameter int LONG_DELAY = 100000000
) (
  input logic clk,
  input logic rst,
  button_debounce_multi_if.slave bus
);
  logic [CHANNELS-1:0] level_v, press_v, rel_v, long_v;

  if (DELAY < 2 || LONG_DELAY <= DELAY || CHANNELS < 1 || CHANNELS > 16) begin : g_bad_cfg
    $error("button_debounce_multi: illegal parameter set");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    btn_debounce_lane #(
      .DELAY(DELAY)
`ifdef BTN_LONG_PRESS_EN
      , .HOLD_CYC(LONG_DELAY - DELAY)
`endif
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .button(bus.button[i]),
      .level (level_v[i]),
      .press (press_v[i]),
      .rel   (rel_v[i]),
      .long_p(long_v[i])
    );
  end

  assign bus.btn_level   = level_v;
  assign bus.btn_press   = press_v;
  assign bus.btn_release = rel_v;
  assign bus.btn_long    = long_v;
endmodule

// File: tb/tb_button_debounce_multi.sv
// Randomized and directed bench for button_debounce_multi against a stable-run reference model.
module tb_button_debounce_multi;
  localparam int D  = 4;
  localparam int LD = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  button_debounce_multi_if #(.CHANNELS(2)) tbif ();

  button_debounce_multi #(.CHANNELS(2), .DELAY(D), .LONG_DELAY(LD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(tbif)
  );

  always #5 clk = ~clk;

  // Reference: a channel flips its accepted level once the synchronised input
  // has disagreed with it for D consecutive edges; outputs show one edge later.
  logic [1:0] m_r1, m_r2, m_lvl, m_ps, pend_p, pend_r, pend_l;
  logic [1:0] e_lvl, e_press, e_rel, e_long;
  int run [2];
`ifdef BTN_LONG_PRESS_EN
  int hold [2];
`endif

  task automatic tick(input logic [1:0] b, input logic r);
    @(negedge clk);
    tbif.button = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_r1 = '0; m_r2 = '0; m_lvl = '0; m_ps = '0;
      pend_p = '0; pend_r = '0; pend_l = '0;
      e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
      for (int c = 0; c < 2; c++) begin
        run[c] = 0;
`ifdef BTN_LONG_PRESS_EN
        hold[c] = 0;
`endif
      end
    end else begin
      e_lvl = m_lvl; e_press = pend_p; e_rel = pend_r; e_long = pend_l;
      pend_p = '0; pend_r = '0; pend_l = '0;
      for (int c = 0; c < 2; c++) begin
        logic s;
        s = m_r2[c];
`ifdef BTN_LONG_PRESS_EN
        if (m_lvl[c] && s && m_ps[c] && hold[c] < LD - D) begin
          hold[c]++;
          if (hold[c] == LD - D) pend_l[c] = 1'b1;
        end
`endif
        if (s != m_lvl[c]) begin
          run[c]++;
          if (run[c] == D) begin
            m_lvl[c] = s;
            run[c] = 0;
            if (s) begin
              pend_p[c] = 1'b1;
`ifdef BTN_LONG_PRESS_EN
              hold[c] = 0;
`endif
            end else pend_r[c] = 1'b1;
          end
        end else run[c] = 0;
        m_ps[c] = s;
      end
      m_r2 = m_r1;
      m_r1 = b;
    end
    #1;
  endtask

  task automatic quiesce();
    tick(2'b00, 1'b1);
    tick(2'b00, 1'b0);
    tick(2'b00, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(2'b11, 1'b1);
      n_chk++;
      if ({tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level} !== 8'h00)
        $display("FAIL reset cyc=%0d got=%b exp=00000000", i,
                 {tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level});
      else n_pass++;
    end
    for (int i = 0; i < 9; i++) begin
      tick(2'b11, 1'b0);
      n_chk++;
      if (tbif.btn_press !== ((i == 6) ? 2'b11 : 2'b00))
        $display("FAIL reset_exit_press cyc=%0d got=%b exp=%b", i, tbif.btn_press,
                 (i == 6) ? 2'b11 : 2'b00);
      else n_pass++;
      n_chk++;
      if ({tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level} !== {e_long, e_rel, e_press, e_lvl})
        $display("FAIL reset_exit_model cyc=%0d got=%b exp=%b", i,
                 {tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level}, {e_long, e_rel, e_press, e_lvl});
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    quiesce();
    for (int i = 0; i < 10; i++) begin
      tick(2'b01, 1'b0);
      n_chk++;
      if (tbif.btn_press !== ((i == 6) ? 2'b01 : 2'b00) || tbif.btn_level !== ((i >= 6) ? 2'b01 : 2'b00))
        $display("FAIL clean_press cyc=%0d got press=%b level=%b", i, tbif.btn_press, tbif.btn_level);
      else n_pass++;
    end
    for (int i = 0; i < 10; i++) begin
      tick(2'b00, 1'b0);
      n_chk++;
      if ({tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level} !== {e_long, e_rel, e_press, e_lvl})
        $display("FAIL clean_release cyc=%0d got=%b exp=%b", i,
                 {tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level}, {e_long, e_rel, e_press, e_lvl});
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [13:0] pat;
    pat = 14'b11111111110111;  // bit i drives tick i: 3 high, 1 low, 10 high
    quiesce();
    for (int i = 0; i < 14; i++) begin
      tick({1'b0, pat[i]}, 1'b0);
      n_chk++;
      if (tbif.btn_press !== ((i == 10) ? 2'b01 : 2'b00))
        $display("FAIL bounce cyc=%0d got press=%b", i, tbif.btn_press);
      else n_pass++;
    end
  endtask

  task automatic test_release_glitch();
    quiesce();
    for (int i = 0; i < 8; i++) tick(2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick((i < 2) ? 2'b00 : 2'b01, 1'b0);
      n_chk++;
      if (tbif.btn_level !== 2'b01 || tbif.btn_release !== 2'b00)
        $display("FAIL release_glitch cyc=%0d got level=%b release=%b", i, tbif.btn_level, tbif.btn_release);
      else n_pass++;
    end
    for (int i = 0; i < 9; i++) begin
      tick(2'b00, 1'b0);
      n_chk++;
      if (tbif.btn_release !== ((i == 6) ? 2'b01 : 2'b00) || tbif.btn_level !== ((i >= 6) ? 2'b00 : 2'b01))
        $display("FAIL clean_drop cyc=%0d got release=%b level=%b", i, tbif.btn_release, tbif.btn_level);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    quiesce();
    for (int i = 0; i < 8; i++) begin
      tick(2'b11, 1'b0);
      n_chk++;
      if (tbif.btn_press !== ((i == 6) ? 2'b11 : 2'b00))
        $display("FAIL simultaneous cyc=%0d got press=%b", i, tbif.btn_press);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) tick(2'b00, 1'b0);
    for (int i = 0; i < 3; i++) tick(2'b11, 1'b0);
    tick(2'b11, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(2'b00, 1'b0);
      n_chk++;
      if ({tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level} !== 8'h00)
        $display("FAIL mid_window_reset cyc=%0d got=%b exp=00000000", i,
                 {tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level});
      else n_pass++;
    end
  endtask

  task automatic test_long_press();
    logic [1:0] lexp;
    quiesce();
    for (int i = 0; i < 40; i++) begin
      tick((i < 30) ? 2'b10 : 2'b00, 1'b0);
`ifdef BTN_LONG_PRESS_EN
      lexp = (i == 22) ? 2'b10 : 2'b00;
`else
      lexp = 2'b00;
`endif
      n_chk++;
      if (tbif.btn_press !== ((i == 6) ? 2'b10 : 2'b00) || tbif.btn_long !== lexp ||
          tbif.btn_release !== ((i == 36) ? 2'b10 : 2'b00))
        $display("FAIL long_press cyc=%0d got press=%b long=%b release=%b long_exp=%b", i,
                 tbif.btn_press, tbif.btn_long, tbif.btn_release, lexp);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [1:0] b;
    int left [2];
    b = 2'b00; left[0] = 0; left[1] = 0;
    quiesce();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (left[c] == 0) begin
          b[c] = ~b[c];
          left[c] = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 30) : $urandom_range(1, 8);
        end
        left[c]--;
      end
      tick(b, $urandom_range(0, 149) == 0);
      n_chk++;
      if ({tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level} !== {e_long, e_rel, e_press, e_lvl})
        $display("FAIL random cyc=%0d got=%b exp=%b", i,
                 {tbif.btn_long, tbif.btn_release, tbif.btn_press, tbif.btn_level}, {e_long, e_rel, e_press, e_lvl});
      else n_pass++;
    end
  endtask

  initial begin
    tbif.button = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_simultaneous();
    test_long_press();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Debounces CHANNELS independent active-high raw button inputs; each channel has its own 2-flop synchroniser, stability counter and FSM.
- Outputs per channel: a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between board button pins and the control/menu FSMs.
- Unlike the single-button version, a bounce mid-window restarts the stability check, so no press is ever accepted on a glitch.

Parameters:
- CHANNELS, 4: number of independent button channels (1..16).
- DELAY, 1500000: required stable-input duration in clk cycles (15 ms at 100 MHz); must be at least 2.
- LONG_DELAY, 100000000: hold duration in cycles for long-press detection (1 s at 100 MHz); used only with BTN_LONG_PRESS_EN; must be greater than DELAY.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- button  input  CHANNELS  raw asynchronous button inputs, 1 = pressed.
- btn_level  output  CHANNELS  debounced level per channel, registered.
- btn_press  output  CHANNELS  one-cycle pulse when a press is accepted.
- btn_release  output  CHANNELS  one-cycle pulse when a release is accepted.
- btn_long  output  CHANNELS  one-cycle long-press pulse; tied to 0 when the feature is off.

Behaviour:
- Reset: synchronous and active-high. While rst=1 at a clock edge:
  - all synchroniser flops, counters, btn_level, btn_press, btn_release and btn_long clear to 0;
  - every FSM goes to IDLE.
  - Reset asserted mid-window aborts the window; no pulse is emitted on exit from reset.
- Synchroniser: s[i] is button[i] after two flops (2-cycle delay). All FSM decisions use s[i] only.
- Counter: one per channel, width $clog2(LONG_DELAY+1). Saturates and never wraps.
- Per-channel FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
  - IDLE (level=0): if s=1, go to PRESS_CHK with cnt=1. Otherwise stay, cnt=0.
  - PRESS_CHK:
    - s=0: back to IDLE, cnt=0. The bounce restarts the check.
    - s=1 and cnt==DELAY-1: go to HELD, cnt=0, btn_level<=1, btn_press<=1 for one cycle.
    - else: cnt+1.
  - HELD (level=1):
    - s=0: go to REL_CHK, cnt_rel=1.
    - else: cnt increments toward LONG_DELAY, used only by the optional feature.
  - REL_CHK:
    - s=1: back to HELD. btn_level stays 1, no pulses, long-press count resumes from its held value.
    - s=0 and cnt_rel==DELAY-1: go to IDLE, btn_level<=0, btn_release<=1 for one cycle.
    - else: cnt_rel+1.
  - REL_CHK uses a separate release counter, so the long-press count is not disturbed.
- Latency: if raw button is 1 at every sampling edge from edge k onward, btn_level and btn_press are 1 after edge k+2+DELAY. Release latency is symmetric.
- A pulse shorter than DELAY stable cycles (after sync) produces no output change.
- Pulses: at most one of btn_press / btn_release / btn_long is high per channel per cycle. Press and release are separated by at least DELAY cycles.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.
- Defined:
  - In HELD, when the hold count reaches LONG_DELAY-DELAY cycles after press acceptance (LONG_DELAY cycles total stable), btn_long[i] pulses for one cycle.
  - The hold counter then saturates, so only one long pulse is emitted per press.
  - The hold counter clears on entry to IDLE.
  - btn_release still fires on the later release.
- Undefined:
  - btn_long is constant 0.
  - The hold counter is not incremented in HELD, and the counter width may shrink to $clog2(DELAY+1).

Test Plan:
- Bench uses CHANNELS=2, DELAY=4, LONG_DELAY=20.
1. Reset: rst=1 for 3 cycles with button=2'b11 -> all outputs 0. After release of rst with button held, btn_press[1:0]=11 exactly at edge 2+4 after the first post-reset sample.
2. Clean press: button[0] 0->1 held 10 cycles -> btn_level[0] rises 6 cycles after the input edge; btn_press[0] high exactly 1 cycle; channel 1 outputs stay 0.
3. Bounce: button[0] high 3 cycles, low 1 cycle, high 10 cycles -> no press during the first burst; btn_press[0] 6 cycles after the second rising edge.
4. Release glitch: in HELD, button[0] drops for 2 cycles then returns -> btn_level[0] stays 1, no btn_release. A later clean drop gives btn_release after 6 cycles.
5. Simultaneous channels: button=2'b11 at the same edge -> btn_press=2'b11 in the same cycle. Reset asserted mid-PRESS_CHK -> no pulse; FSM in IDLE on the next cycle.
6. Long press (macro defined): hold button[1] for 30 cycles -> btn_press[1] at cycle 6, a single btn_long[1] at cycle 22, btn_release[1] 6 cycles after the drop. With the macro undefined, btn_long stays 0.
